// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: shares one RAM between a video scan reader and a
// CPU read/write port, with a built-in zero-fill engine after reset or on command.
module vram_arbiter #(
  parameter int data_width    = 8,
  parameter int address_width = 10,
  parameter int cpu_wait_max  = 4
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     clear_start,
  output logic                     clear_busy,

  input  logic                     vid_req,
  input  logic [address_width-1:0] vid_addr,
  output logic                     vid_valid,
  output logic [data_width-1:0]    vid_q,
  output logic                     vid_miss,

  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [address_width-1:0] cpu_addr,
  input  logic [data_width-1:0]    cpu_din,
  output logic [data_width-1:0]    cpu_dout,
  output logic                     cpu_ack,

  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  output logic                     ram_wren,
  input  logic [data_width-1:0]    ram_q
);

  localparam int wait_width = $clog2(cpu_wait_max + 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                   state;
  state_t                   state_nx;

  logic [address_width-1:0] clear_cnt;
  logic                     clear_last;

  logic                     cpu_busy;
  logic [wait_width-1:0]    wait_cnt;

  logic                     vid_p1;
  logic                     vid_p2;
  logic                     cpu_p1;
  logic                     cpu_p2;

  logic                     cpu_ok;
  logic                     starved;
  logic                     slot_open;
  logic                     grant_vid;
  logic                     grant_cpu;

  assign clear_busy = (state == CLEAR);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    cpu_ok    = 1'b0;
    starved   = 1'b0;
    slot_open = 1'b0;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;

    // The CPU is deaf while its access is in flight and during its ack cycle.
    cpu_ok    = cpu_req && !cpu_busy && !cpu_ack;
    starved   = (wait_cnt >= wait_width'(cpu_wait_max));
    slot_open = (state == RUN) && !clear_start;
    grant_vid = slot_open && vid_req && !starved;
    grant_cpu = slot_open && !grant_vid && cpu_ok;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clear_last)  state_nx = RUN;
      RUN:     if (clear_start) state_nx = CLEAR;
      default:                  state_nx = CLEAR;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  // RAM port: zero-fill sweep, or one granted slot per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_cnt   <= '0;
      clear_last  <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else if (state == CLEAR) begin
      if (clear_last) begin
        ram_wren   <= 1'b0;
        clear_last <= 1'b0;
      end else begin
        ram_address <= clear_cnt;
        ram_data    <= '0;
        ram_wren    <= 1'b1;
        clear_cnt   <= clear_cnt + 1'b1;
        clear_last  <= (clear_cnt == '1);
      end
    end else if (grant_vid) begin
      ram_address <= vid_addr;
      ram_wren    <= 1'b0;
    end else if (grant_cpu) begin
      ram_address <= cpu_addr;
      ram_data    <= cpu_din;
      ram_wren    <= cpu_we;
    end else begin
      ram_wren <= 1'b0;
    end
  end

  // Two-stage return pipelines: grant at k, RAM samples at k+1, capture at k+2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_p1    <= 1'b0;
      vid_p2    <= 1'b0;
      vid_valid <= 1'b0;
      vid_q     <= '0;
      vid_miss  <= 1'b0;
      cpu_p1    <= 1'b0;
      cpu_p2    <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_dout  <= '0;
      cpu_busy  <= 1'b0;
    end else begin
      vid_p1    <= grant_vid;
      vid_p2    <= vid_p1;
      vid_valid <= vid_p2;
      if (vid_p2) vid_q <= ram_q;
      vid_miss  <= (state == CLEAR) && vid_req;

      cpu_p1    <= grant_cpu;
      cpu_p2    <= cpu_p1;
      cpu_ack   <= cpu_p2;
      // The RAM is write-through, so ram_q carries the write data on writes.
      if (cpu_p2) cpu_dout <= ram_q;

      if (grant_cpu)   cpu_busy <= 1'b1;
      else if (cpu_p2) cpu_busy <= 1'b0;
    end
  end

  // Counts slots an eligible CPU request has lost to video.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!cpu_req || grant_cpu) begin
      wait_cnt <= '0;
    end else if (grant_vid && cpu_ok) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter (address_width=4) with a behavioural
// write-through single-port RAM attached to the RAM port.
module tb_vram_arbiter;

  localparam int dw = 8;
  localparam int aw = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic          vid_req = 1'b0;
  logic [aw-1:0] vid_addr = '0;
  logic          vid_valid;
  logic [dw-1:0] vid_q;
  logic          vid_miss;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [aw-1:0] cpu_addr = '0;
  logic [dw-1:0] cpu_din = '0;
  logic [dw-1:0] cpu_dout;
  logic          cpu_ack;
  logic [aw-1:0] ram_address;
  logic [dw-1:0] ram_data;
  logic          ram_wren;
  logic [dw-1:0] ram_q;

  logic [dw-1:0] mem [2**aw];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .data_width   (dw),
    .address_width(aw),
    .cpu_wait_max (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_valid  (vid_valid),
    .vid_q      (vid_q),
    .vid_miss   (vid_miss),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_ack    (cpu_ack),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_address] <= ram_data;
      ram_q            <= ram_data;
    end else begin
      ram_q <= mem[ram_address];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  clear_busy,  1);
    check({tag, "_wren"},  ram_wren,    0);
    check({tag, "_addr"},  ram_address, 0);
    check({tag, "_data"},  ram_data,    0);
    check({tag, "_ack"},   cpu_ack,     0);
    check({tag, "_dout"},  cpu_dout,    0);
    check({tag, "_vv"},    vid_valid,   0);
    check({tag, "_vq"},    vid_q,       0);
    check({tag, "_vmiss"}, vid_miss,    0);
  endtask

  // Follows a full zero-fill sweep from reset release to the return to RUN.
  task automatic run_clear(input string tag);
    int busy_cnt = 0;
    int resp     = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (cpu_ack || vid_valid) resp++;
      if (!clear_busy) break;
      check({tag, "_wr"},   {31'd0, ram_wren}, 1);
      check({tag, "_addr"}, ram_address,       busy_cnt);
      check({tag, "_zero"}, ram_data,          0);
      busy_cnt++;
    end
    check({tag, "_cycles"},  busy_cnt, 16);
    check({tag, "_wr_end"},  ram_wren, 0);
    check({tag, "_no_resp"}, resp,     0);
  endtask

  task automatic cpu_xfer(input logic we, input logic [aw-1:0] a, input logic [dw-1:0] d,
                          output logic [dw-1:0] q, output int lat);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    lat      = 0;
    q        = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      lat++;
      if (cpu_ack) begin
        q = cpu_dout;
        break;
      end
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    step();
  endtask

  initial begin
    logic [dw-1:0] q;
    int            lat;
    logic [10:1]   vv_exp;
    logic [dw-1:0] vq_exp [3];
    int            edge_no;
    int            vv_cnt;
    logic          ack_seen;

    // Reset state and the power-on clear.
    #1 reset = 1'b1;
    step();
    step();
    check_reset_values("rst");
    reset = 1'b0;
    run_clear("clr1");

    // CPU write then read back; ack lands 2 edges after the grant.
    cpu_xfer(1'b1, 4'h3, 8'hA5, q, lat);
    check("wr_lat",  lat, 3);
    check("wr_dout", q,   8'hA5);
    cpu_xfer(1'b0, 4'h3, 8'h00, q, lat);
    check("rd_lat",  lat, 3);
    check("rd_dout", q,   8'hA5);

    // Full-rate video scan.
    cpu_xfer(1'b1, 4'h0, 8'h11, q, lat);
    cpu_xfer(1'b1, 4'h1, 8'h22, q, lat);
    cpu_xfer(1'b1, 4'h2, 8'h33, q, lat);
    vq_exp[0] = 8'h11;
    vq_exp[1] = 8'h22;
    vq_exp[2] = 8'h33;
    vid_req  = 1'b1;
    vid_addr = 4'h0;
    for (int j = 1; j <= 6; j++) begin
      step();
      if (j < 3) vid_addr = aw'(j);
      else       vid_req  = 1'b0;
      check("scan_vv", vid_valid, (j >= 3 && j <= 5));
      if (j >= 3 && j <= 5) check("scan_vq", vid_q, vq_exp[j-3]);
    end

    // Starvation: CPU forced through on the 5th contending edge.
    vv_exp   = 10'b1110111100;
    vid_req  = 1'b1;
    vid_addr = 4'h1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 4'h5;
    for (int j = 1; j <= 10; j++) begin
      step();
      check("starve_vv",  vid_valid, vv_exp[j]);
      check("starve_ack", cpu_ack,   (j == 7));
      if (vid_valid) check("starve_vq", vid_q, 8'h22);
      if (j == 5) begin
        check("starve_gaddr", ram_address, 5);
        check("starve_gwr",   ram_wren,    0);
      end
      if (cpu_ack) begin
        check("starve_dout", cpu_dout, 0);
        cpu_req = 1'b0;
      end
    end
    vid_req = 1'b0;
    step();
    step();
    step();

    // Clear while the CPU is in flight, with video and a second CPU request pending.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 4'h1;
    step();
    check("cl_gaddr", ram_address, 1);
    clear_start = 1'b1;
    vid_req     = 1'b1;
    vid_addr    = 4'h2;
    step();
    clear_start = 1'b0;
    check("cl_busy_e2", clear_busy, 1);
    check("cl_miss_e2", vid_miss,   0);
    check("cl_ack_e2",  cpu_ack,    0);
    step();
    check("cl_ack_e3",  cpu_ack,    1);
    check("cl_dout_e3", cpu_dout,   8'h22);
    check("cl_miss_e3", vid_miss,   1);
    check("cl_vv_e3",   vid_valid,  0);
    cpu_addr = 4'h2;
    step();
    check("cl_miss_e4", vid_miss, 1);
    check("cl_ack_e4",  cpu_ack,  0);
    vid_req = 1'b0;
    step();
    check("cl_miss_e5", vid_miss, 0);
    edge_no  = 5;
    vv_cnt   = 0;
    ack_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      edge_no++;
      clear_start = (edge_no == 10);
      if (vid_valid) vv_cnt++;
      if (cpu_ack) begin
        ack_seen = 1'b1;
        break;
      end
    end
    check("cl_ack2",      ack_seen,   1);
    check("cl_ack2_edge", edge_no,    22);
    check("cl_dout2",     cpu_dout,   0);
    check("cl_busy_end",  clear_busy, 0);
    check("cl_no_vv",     vv_cnt,     0);
    cpu_req     = 1'b0;
    clear_start = 1'b0;
    step();

    // Reset one edge after a CPU write grant.
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 4'h4;
    cpu_din  = 8'h77;
    step();
    check("mr_gwr",   ram_wren,    1);
    check("mr_gaddr", ram_address, 4);
    step();
    reset   = 1'b1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    #1;
    check_reset_values("mr");
    step();
    check("mr_ack_hold", cpu_ack, 0);
    step();
    reset = 1'b0;
    run_clear("clr2");
    cpu_xfer(1'b0, 4'h4, 8'h00, q, lat);
    check("mr_rd_lat",  lat, 3);
    check("mr_rd_dout", q,   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
